// File: rtl/cam_entry_manager.sv
// cam_entry_manager: insert/delete front end for the shift-register CAM; `define CAM_MGR_STATS_EN adds saturating stat counters.
module cam_entry_manager #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_op,
  input  logic [DATA_WIDTH-1:0]    req_data,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDR_WIDTH-1:0]    rsp_addr,
  output logic [1:0]               rsp_status,
  output logic [ADDR_WIDTH-1:0]    cam_write_addr,
  output logic [DATA_WIDTH-1:0]    cam_write_data,
  output logic                     cam_write_delete,
  output logic                     cam_write_enable,
  input  logic                     cam_write_busy,
  output logic [2**ADDR_WIDTH-1:0] valid_mask,
  output logic [ADDR_WIDTH:0]      entry_count,
  output logic [15:0]              stat_insert,
  output logic [15:0]              stat_delete,
  output logic [15:0]              stat_reject
);
  localparam int ENTRIES = 2**ADDR_WIDTH;
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT_START = 3'd2, WAIT_DONE = 3'd3, RESP = 3'd4;
  localparam logic [1:0] ST_OK = 2'd0, ST_FULL = 2'd1, ST_NOT_VALID = 2'd2;
  logic [2:0]            state;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [ADDR_WIDTH-1:0] free_addr;
  logic                  full;
  logic                  accept;
  logic                  rsp_fire;
  // Lowest index wins: scan downward so the last hit is the smallest free slot.
  always_comb begin
    free_addr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid_mask[i]) free_addr = ADDR_WIDTH'(i);
  end
  assign full      = &valid_mask;
  assign req_ready = rst_n && state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      op_q             <= 1'b0;
      addr_q           <= '0;
      key_q            <= '0;
      rsp_addr         <= '0;
      rsp_status       <= ST_OK;
      cam_write_addr   <= '0;
      cam_write_data   <= '0;
      cam_write_delete <= 1'b0;
      cam_write_enable <= 1'b0;
      valid_mask       <= '0;
      entry_count      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= req_op;
          if (!req_op && full) begin
            rsp_status <= ST_FULL;
            rsp_addr   <= '0;
            state      <= RESP;
          end else if (!req_op) begin
            key_q  <= req_data;
            addr_q <= free_addr;
            state  <= ISSUE;
          end else if (!valid_mask[req_addr]) begin
            rsp_status <= ST_NOT_VALID;
            rsp_addr   <= req_addr;
            state      <= RESP;
          end else begin
            addr_q <= req_addr;
            state  <= ISSUE;
          end
        end
        ISSUE: if (!cam_write_busy) begin
          cam_write_enable <= 1'b1;
          cam_write_addr   <= addr_q;
          cam_write_data   <= key_q;
          cam_write_delete <= op_q;
          state            <= WAIT_START;
        end
        // CAM raises busy one cycle after enable, so busy is not trusted here.
        WAIT_START: begin
          cam_write_enable <= 1'b0;
          state            <= WAIT_DONE;
        end
        WAIT_DONE: if (!cam_write_busy) begin
          valid_mask[addr_q] <= !op_q;
          entry_count        <= op_q ? entry_count - 1'b1 : entry_count + 1'b1;
          rsp_status         <= ST_OK;
          rsp_addr           <= addr_q;
          state              <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CAM_MGR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_insert <= '0;
      stat_delete <= '0;
      stat_reject <= '0;
    end else if (rsp_fire) begin
      if (rsp_status != ST_OK && stat_reject != 16'hFFFF) stat_reject <= stat_reject + 1'b1;
      if (rsp_status == ST_OK && !op_q && stat_insert != 16'hFFFF) stat_insert <= stat_insert + 1'b1;
      if (rsp_status == ST_OK && op_q && stat_delete != 16'hFFFF) stat_delete <= stat_delete + 1'b1;
    end
  end
`else
  assign stat_insert = '0;
  assign stat_delete = '0;
  assign stat_reject = '0;
`endif
endmodule
